// File: rtl/tx_packet_ctrl_pkg.sv
// tx_pkg: shared PID/SYNC constants, packet-kind and controller state types
package tx_pkg;
  localparam logic [7:0] SYNC      = 8'h80;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  typedef enum logic [1:0] {PT_ACK, PT_NAK, PT_STALL, PT_DATA} pkt_t;
  typedef enum logic [3:0] {
    IDLE, LOAD_SYNC, WAIT_SYNC, WAIT_PID, LOAD_DATA, WAIT_DATA,
    CRC1, CRC2, EOP1, EOP2, EOP_IDLE
  } state_t;
  function automatic logic [7:0] pid_of(pkt_t t, logic tog);
    return t == PT_ACK ? PID_ACK : t == PT_NAK ? PID_NAK :
           t == PT_STALL ? PID_STALL : tog ? PID_DATA1 : PID_DATA0;
  endfunction
endpackage

// File: rtl/tx_packet_ctrl_if.sv
// tx_packet_ctrl_if: request/byte-transmitter bus of the packet controller
// master: requester side (drives send_req, pkt_type, payload_len, byte_done, ack_rcvd, clear_toggle)
// slave:  controller side (drives tx_byte, strobes, busy, pkt_done)
interface tx_packet_ctrl_if import tx_pkg::*; #(parameter int CNT_W = 7);
  logic             send_req;
  pkt_t             pkt_type;
  logic [CNT_W-1:0] payload_len;
  logic             byte_done;
  logic             ack_rcvd;
  logic             clear_toggle;
  logic [7:0]       tx_byte;
  logic             load_en;
  logic             select;
  logic             fifo_r_enable;
  logic             calc_crc;
  logic             send_crc;
  logic             eop;
  logic             eop_new_bit;
  logic             busy;
  logic             pkt_done;
  modport master (
    output send_req, pkt_type, payload_len, byte_done, ack_rcvd, clear_toggle,
    input  tx_byte, load_en, select, fifo_r_enable, calc_crc, send_crc,
           eop, eop_new_bit, busy, pkt_done
  );
  modport slave (
    input  send_req, pkt_type, payload_len, byte_done, ack_rcvd, clear_toggle,
    output tx_byte, load_en, select, fifo_r_enable, calc_crc, send_crc,
           eop, eop_new_bit, busy, pkt_done
  );
endinterface

// File: rtl/tx_packet_ctrl_counter.sv
// payload_counter: payload byte down-counter plus DATA0/DATA1 toggle
// i_load/i_len load the counter, i_dec decrements; i_clear/i_ack drive the toggle, i_hold freezes it
// o_last: counter == 1, o_more: counter > 1, o_toggle: current data toggle
module payload_counter #(parameter int CNT_W = 7) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic             i_clear,
  input  logic             i_ack,
  input  logic             i_hold,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_last,
  output logic             o_more,
  output logic             o_toggle
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_toggle;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_cnt    <= '0;
      r_toggle <= 1'b0;
    end else begin
      r_cnt    <= i_load ? i_len : i_dec ? r_cnt - 1'b1 : r_cnt;
      r_toggle <= i_hold ? r_toggle : i_clear ? 1'b0 : i_ack ? ~r_toggle : r_toggle;
    end
  assign o_last   = r_cnt == CNT_W'(1);
  assign o_more   = r_cnt > CNT_W'(1);
  assign o_toggle = r_toggle;
endmodule

// File: rtl/tx_packet_ctrl.sv
// tx_packet_ctrl: sequences SYNC, PID, payload, CRC16 and EOP for one USB packet
// clk/n_rst plain ports; everything else on bus (tx_packet_ctrl_if.slave)
module tx_packet_ctrl import tx_pkg::*; #(
  parameter int MAX_PAYLOAD = 64,
  parameter int CNT_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic            clk,
  input  logic            n_rst,
  tx_packet_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PAYLOAD);
  state_t           r_state;
  pkt_t             r_type;
  logic [CNT_W-1:0] r_len;
  logic w_data, w_bd, w_start, w_last, w_more, w_toggle;
  assign w_data  = r_type == PT_DATA;
  assign w_bd    = bus.byte_done;
  // PID byte finished on a non-empty DATA packet: first payload byte enters the CRC now
  assign w_start = r_state == WAIT_PID && w_data && w_bd && r_len != '0;
  payload_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_load   (w_start),
    .i_dec    (r_state == WAIT_DATA && w_bd),
    .i_clear  (bus.clear_toggle),
    .i_ack    (bus.ack_rcvd),
    .i_hold   (r_state == WAIT_SYNC && w_data),
    .i_len    (r_len),
    .o_last   (w_last),
    .o_more   (w_more),
    .o_toggle (w_toggle)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_state <= IDLE;
      r_type  <= PT_ACK;
      r_len   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.send_req) begin
          r_state <= LOAD_SYNC;
          r_type  <= bus.pkt_type;
          r_len   <= bus.payload_len > MAX_LEN ? MAX_LEN : bus.payload_len;
        end
        LOAD_SYNC: r_state <= WAIT_SYNC;
        WAIT_SYNC: if (w_bd) r_state <= WAIT_PID;
        WAIT_PID:  if (w_bd) r_state <= !w_data ? EOP1 : r_len != '0 ? LOAD_DATA : CRC1;
        LOAD_DATA: r_state <= WAIT_DATA;
        WAIT_DATA: if (w_bd) r_state <= w_last ? CRC1 : LOAD_DATA;
        CRC1:      if (w_bd) r_state <= CRC2;
        CRC2:      if (w_bd) r_state <= EOP1;
        EOP1:      r_state <= EOP2;
        EOP2:      r_state <= EOP_IDLE;
        EOP_IDLE:  r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  assign bus.tx_byte       = r_state inside {WAIT_SYNC, WAIT_PID} ? pid_of(r_type, w_toggle) : SYNC;
  assign bus.load_en       = r_state == LOAD_SYNC;
  assign bus.select        = !(r_state inside {LOAD_DATA, WAIT_DATA, CRC1, CRC2, EOP1, EOP2} ||
                               (r_state == WAIT_PID && w_data));
  // the last payload byte is not pre-read: it is already waiting in the transmitter
  assign bus.fifo_r_enable = r_state == LOAD_DATA && w_more;
  assign bus.calc_crc      = r_state == LOAD_DATA || w_start ||
                             (r_state == WAIT_DATA && !(w_bd && w_last));
  assign bus.send_crc      = r_state == CRC1 || (r_state == CRC2 && !w_bd);
  assign bus.eop           = r_state inside {EOP1, EOP2};
  assign bus.eop_new_bit   = r_state inside {EOP1, EOP2};
  // illegal encodings fall outside this range and look like IDLE
  assign bus.busy          = r_state inside {[LOAD_SYNC:EOP_IDLE]};
  assign bus.pkt_done      = r_state == EOP_IDLE;
endmodule

// File: tb/tb_tx_packet_ctrl.sv
// tb_tx_packet_ctrl: table-driven packet vectors checked by a pkt_done scoreboard, plus corner sequences
module tb_tx_packet_ctrl;
  import tx_pkg::*;
  localparam int MAXP = 8;
  localparam int CW   = $clog2(MAXP + 1);

  typedef struct {
    logic [7:0] pid;
    int         fifo;
    int         pay;
    int         crc;
    bit         calc_any;
    bit         send_any;
  } exp_t;

  typedef struct {
    pkt_t       typ;
    int         len;
    int         pre;
    logic [7:0] pid;
    int         pay;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  bit   bd_en = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  exp_t sb_q[$];
  vec_t vecs[11];

  int         m_fifo, m_pay, m_crc, m_eop, m_calc, m_send;
  logic [7:0] m_sync, m_pid;
  bit         m_first, m_prev_calc, m_prev_send;

  always #5 clk = ~clk;

  tx_packet_ctrl_if #(.CNT_W(CW)) bus();
  tx_packet_ctrl #(.MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // byte transmitter model: byte_done every third cycle
  initial begin
    int ph = 0;
    bus.byte_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.byte_done = bd_en && ph == 2;
      ph = (ph + 1) % 3;
    end
  end

  // monitor: accumulate per-packet activity, compare against scoreboard on pkt_done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.load_en) begin
        m_sync = bus.tx_byte; m_first = 1'b1; m_pid = 8'h00;
        m_fifo = 0; m_pay = 0; m_crc = 0; m_eop = 0; m_calc = 0; m_send = 0;
        m_prev_calc = 1'b0; m_prev_send = 1'b0;
      end else begin
        if (bus.byte_done && bus.busy && m_first) begin
          m_pid = bus.tx_byte;
          m_first = 1'b0;
        end
        m_fifo += int'(bus.fifo_r_enable);
        m_calc += int'(bus.calc_crc);
        m_send += int'(bus.send_crc);
        m_eop  += int'(bus.eop && bus.eop_new_bit);
        m_pay  += int'(bus.byte_done && m_prev_calc);
        m_crc  += int'(bus.byte_done && m_prev_send);
        m_prev_calc = bus.calc_crc;
        m_prev_send = bus.send_crc;
      end
      if (bus.pkt_done) begin
        n_done++;
        if (sb_q.size() == 0) chk("unexpected_pkt_done", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("sync_byte", int'(m_sync), 32'h80);
          chk("pid", int'(m_pid), int'(e.pid));
          chk("fifo_reads", m_fifo, e.fifo);
          chk("payload_bytes", m_pay, e.pay);
          chk("crc_bytes", m_crc, e.crc);
          chk("eop_cycles", m_eop, 2);
          chk("calc_crc_seen", int'(m_calc > 0), int'(e.calc_any));
          chk("send_crc_seen", int'(m_send > 0), int'(e.send_any));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic push_exp(pkt_t t, logic [7:0] pid, int pay);
    exp_t e;
    e.pid = pid; e.pay = pay; e.fifo = pay > 1 ? pay - 1 : 0;
    e.crc = t == PT_DATA ? 2 : 0; e.calc_any = pay > 0; e.send_any = t == PT_DATA;
    sb_q.push_back(e);
  endtask

  task automatic start_pkt(pkt_t t, int len);
    @(posedge clk); #1;
    bus.send_req = 1'b1; bus.pkt_type = t; bus.payload_len = CW'(len);
    @(posedge clk); #1;
    bus.send_req = 1'b0;
  endtask

  task automatic wait_done(int start);
    int k = 0;
    while (n_done == start && k < 500) begin
      @(posedge clk); k++;
    end
    chk("pkt_done_seen", int'(n_done != start), 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse(bit a, bit c);
    @(posedge clk); #1;
    bus.ack_rcvd = a; bus.clear_toggle = c;
    @(posedge clk); #1;
    bus.ack_rcvd = 1'b0; bus.clear_toggle = 1'b0;
  endtask

  task automatic run_pkt(vec_t v);
    int s;
    if (v.pre == 1) pulse(1'b1, 1'b0);
    if (v.pre == 2) pulse(1'b1, 1'b1);
    push_exp(v.typ, v.pid, v.pay);
    s = n_done;
    start_pkt(v.typ, v.len);
    wait_done(s);
  endtask

  function automatic int out_vec();
    return int'({bus.tx_byte, bus.load_en, bus.select, bus.fifo_r_enable, bus.calc_crc,
                 bus.send_crc, bus.eop, bus.eop_new_bit, bus.busy, bus.pkt_done});
  endfunction

  localparam int IDLE_OUT = 32'h10080;

  initial begin
    int s;
    bus.send_req = 1'b0; bus.pkt_type = PT_ACK; bus.payload_len = '0;
    bus.ack_rcvd = 1'b0; bus.clear_toggle = 1'b0;
    // pre: 0 none, 1 ack_rcvd pulse, 2 clear_toggle+ack_rcvd together
    vecs[0]  = '{PT_NAK,   0,  0, 8'h5A, 0};
    vecs[1]  = '{PT_ACK,   5,  0, 8'hD2, 0};
    vecs[2]  = '{PT_STALL, 0,  0, 8'h1E, 0};
    vecs[3]  = '{PT_DATA,  3,  0, 8'hC3, 3};
    vecs[4]  = '{PT_DATA,  1,  1, 8'h4B, 1};
    vecs[5]  = '{PT_DATA,  2,  2, 8'hC3, 2};
    vecs[6]  = '{PT_DATA,  0,  0, 8'hC3, 0};
    vecs[7]  = '{PT_DATA,  13, 1, 8'h4B, 8};
    vecs[8]  = '{PT_DATA,  8,  0, 8'h4B, 8};
    vecs[9]  = '{PT_DATA,  15, 1, 8'hC3, 8};
    vecs[10] = '{PT_DATA,  9,  2, 8'hC3, 8};

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", out_vec(), IDLE_OUT);
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", out_vec(), IDLE_OUT);

    for (int i = 0; i < 11; i++) run_pkt(vecs[i]);

    // oversize request with a second request while busy: only one packet, nothing queued
    push_exp(PT_DATA, 8'hC3, 8);
    s = n_done;
    start_pkt(PT_DATA, MAXP + 5);
    repeat (8) @(posedge clk); #1;
    bus.send_req = 1'b1; bus.pkt_type = PT_NAK;
    @(posedge clk); #1;
    bus.send_req = 1'b0;
    wait_done(s);
    repeat (6) @(posedge clk); #1;
    chk("busy_req_not_queued", int'(bus.busy), 0);

    // ack_rcvd during WAIT_SYNC of a DATA packet must not alter the PID being sent
    bd_en = 1'b0;
    @(posedge clk); #1;
    push_exp(PT_DATA, 8'hC3, 1);
    s = n_done;
    start_pkt(PT_DATA, 1);
    @(posedge clk); #1;
    bus.ack_rcvd = 1'b1;
    @(posedge clk); #1;
    bus.ack_rcvd = 1'b0;
    bd_en = 1'b1;
    wait_done(s);
    pulse(1'b0, 1'b1);

    // reset in WAIT_DATA with toggle at 1: abort, reset outputs, no pkt_done, toggle back to 0
    pulse(1'b1, 1'b0);
    s = n_done;
    start_pkt(PT_DATA, 5);
    for (int k = 0; k < 100 && !bus.fifo_r_enable; k++) @(negedge clk);
    chk("reached_load_data", int'(bus.fifo_r_enable), 1);
    @(posedge clk); #1;
    chk("in_wait_data_calc", int'(bus.calc_crc), 1);
    n_rst = 1'b0;
    #1;
    chk("async_reset_outputs", out_vec(), IDLE_OUT);
    #1;
    n_rst = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("no_done_after_abort", n_done, s);
    run_pkt('{PT_DATA, 1, 0, 8'hC3, 1});

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_packet_ctrl.md
TX_PACKET_CTRL -- requirements
Module: tx_packet_ctrl

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, meaning the largest DATA payload in bytes (legal 1..1023).
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_PAYLOAD+1), meaning the payload length/counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 n_rst  in  1  asynchronous, active-low reset.
REQ-005 send_req  in  1  one-cycle request to start a packet; sampled only in IDLE.
REQ-006 pkt_type  in  2  packet kind, latched with send_req: 00 ACK, 01 NAK, 10 STALL, 11 DATA.
REQ-007 payload_len  in  CNT_W  DATA payload byte count, latched with send_req; 0 means zero-length packet.
REQ-008 byte_done  in  1  byte-transmitter pulse: current byte finished, next byte taken.
REQ-009 ack_rcvd  in  1  pulse from the receive path: host ACKed the last DATA packet.
REQ-010 clear_toggle  in  1  pulse forcing the data toggle to DATA0.
REQ-011 tx_byte  out  8  byte presented to the byte transmitter.
REQ-012 load_en  out  1  one-cycle load strobe for the byte transmitter.
REQ-013 select  out  1  transmitter mux select: 1 = tx_byte, 0 = FIFO byte.
REQ-014 fifo_r_enable  out  1  FIFO read strobe that advances the next payload byte.
REQ-015 calc_crc  out  1  CRC16 accumulate enable.
REQ-016 send_crc  out  1  CRC16 transmit enable.
REQ-017 eop, eop_new_bit  out  1 each  asserted together to drive SE0 EOP bits.
REQ-018 busy  out  1  high whenever not in IDLE.
REQ-019 pkt_done  out  1  one-cycle pulse on the return to IDLE.

Function
REQ-020 SHALL use constants SYNC 0x80, ACK 0xD2, NAK 0x5A, STALL 0x1E, DATA0 0xC3, DATA1 0x4B.
REQ-021 SHALL implement Moore states IDLE, LOAD_SYNC, WAIT_SYNC, WAIT_PID, LOAD_DATA, WAIT_DATA, CRC1, CRC2, EOP1, EOP2, EOP_IDLE.
REQ-022 IDLE: on send_req, latch pkt_type and min(payload_len, MAX_PAYLOAD), then go to LOAD_SYNC; otherwise stay.
REQ-023 LOAD_SYNC: tx_byte=SYNC, load_en=1, select=1; next state is WAIT_SYNC.
REQ-024 WAIT_SYNC: tx_byte=PID of the latched type (DATA uses the current toggle); on byte_done go to WAIT_PID.
REQ-025 WAIT_PID, handshake types: hold select=1; on byte_done go to EOP1.
REQ-026 WAIT_PID, DATA: select=0.
REQ-026a On byte_done with len>0: load the counter with len, assert calc_crc, go to LOAD_DATA.
REQ-026b On byte_done with len=0: go to CRC1 with calc_crc held low.
REQ-027 LOAD_DATA: calc_crc=1; fifo_r_enable=1 only if the counter is >1; next state is WAIT_DATA.
REQ-028 WAIT_DATA: calc_crc=1; on byte_done, decrement the counter.
REQ-028a If the pre-decrement counter is 1, go to CRC1 and drop calc_crc that cycle.
REQ-028b Otherwise go to LOAD_DATA.
REQ-029 CRC1 and CRC2: send_crc=1, select=0; each advances on byte_done.
REQ-029a send_crc SHALL drop in the cycle CRC2 sees byte_done.
REQ-030 EOP1 and EOP2: eop=eop_new_bit=1 for exactly one cycle each.
REQ-031 EOP_IDLE: all strobes low, pkt_done=1; next state is IDLE.
REQ-032 busy SHALL be 0 only in IDLE; send_req while busy SHALL be ignored and not queued.
REQ-033 Data toggle: clear_toggle sets it to 0; otherwise ack_rcvd inverts it.
REQ-033a Simultaneous clear_toggle and ack_rcvd: clear wins.
REQ-033b The toggle SHALL not change during a DATA packet's WAIT_SYNC.
REQ-034 byte_done outside the WAIT_* or CRC states SHALL be ignored.
REQ-035 All outputs SHALL be combinational from state and latched registers only, except calc_crc/send_crc edge cases in REQ-026a, REQ-028a and REQ-029a.
REQ-036 Illegal state encodings SHALL go to IDLE with the IDLE output set.

Reset
REQ-037 On n_rst low, asynchronously:
- state=IDLE, toggle=0, counter=0, latched type=ACK, latched len=0.
- Outputs: tx_byte=0x80, select=1, all other outputs 0.
REQ-038 Reset asserted mid-packet SHALL abort it with no pkt_done pulse.

Structure
REQ-039 SHALL place the PID/SYNC constants, the pkt_type enum and the state enum in the shared package tx_pkg.
REQ-040 SHALL keep the payload down-counter and data toggle as an in-module sub-block payload_counter (counter, toggle, terminal flag).

Verification
REQ-041 NAK request: SYNC load, then 0x5A, then 2 EOP cycles, then pkt_done; calc_crc and send_crc never asserted.
REQ-042 DATA with len=3, toggle 0:
- PID 0xC3.
- Exactly 2 fifo_r_enable pulses.
- calc_crc high across 3 bytes.
- 2 send_crc byte_done, then EOP.
REQ-043 ack_rcvd then DATA len=1: PID 0x4B; clear_toggle and ack_rcvd in the same cycle then DATA: PID 0xC3.
REQ-044 DATA len=0: PID, then CRC1 and CRC2 directly, with no fifo_r_enable and no calc_crc.
REQ-045 payload_len=MAX_PAYLOAD+5 with MAX_PAYLOAD=8: exactly 8 payload bytes sent; send_req during busy has no effect.
REQ-046 n_rst pulsed during WAIT_DATA: immediate IDLE, reset output set, toggle=0, no pkt_done.
